// File: rtl/axi_pkg.sv
// Shared encodings for the AXI address-channel burst splitter.
// No logic; constants and types only.
// No flow control of its own.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    // An INCR sub-burst must stay inside one 2^PAGE_BITS byte page.
    localparam int         PAGE_BITS  = 12;
    localparam logic [12:0] PAGE_BYTES = 13'd4096;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/axi_split_calc.sv
// Sizes one INCR sub-burst: min(remaining beats, MAX_BEATS, beats to page end).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the result.
module axi_split_calc
    import axi_pkg::*;
#(
    parameter int AW        = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic [AW-1:0] addr,
    input  logic [8:0]    rem,
    input  logic [2:0]    size,
    output logic [8:0]    chunk,
    output logic [7:0]    s_len,
    output logic          s_last,
    output logic [AW-1:0] next_addr
);

    localparam logic [8:0] MAX_CHUNK = 9'(MAX_BEATS);

    logic [AW-1:0] alig;
    logic [12:0]   tob;
    logic [8:0]    lim;

    always_comb begin
        alig      = addr & ~((AW'(1) << size) - AW'(1));
        // tob is never zero: alig is size-aligned, so the distance is at least one beat.
        tob       = (PAGE_BYTES - {1'b0, alig[PAGE_BITS-1:0]}) >> size;
        lim       = (rem < MAX_CHUNK) ? rem : MAX_CHUNK;
        chunk     = (13'(lim) < tob) ? lim : tob[8:0];
        s_len     = 8'(chunk - 9'd1);
        s_last    = (rem == chunk);
        next_addr = alig + (AW'(chunk) << size);
    end

endmodule

// File: rtl/axi_burst_split.sv
// Splits AXI4 INCR address commands into sub-bursts bounded by 4 KB pages and MAX_BEATS.
// Latency: accept at edge N -> first sub-burst valid from edge N+1; one sub-burst per s handshake.
// Backpressure: s_* held stable while s_valid & !s_ready; m_ready low for the whole split.
module axi_burst_split
    import axi_pkg::*;
#(
    parameter int AW        = 32,
    parameter int IDW       = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [AW-1:0]  m_addr,
    input  logic [7:0]     m_len,
    input  logic [2:0]     m_size,
    input  logic [1:0]     m_burst,
    input  logic [IDW-1:0] m_id,
    input  logic           m_valid,
    output logic           m_ready,
    output logic [AW-1:0]  s_addr,
    output logic [7:0]     s_len,
    output logic [2:0]     s_size,
    output logic [1:0]     s_burst,
    output logic [IDW-1:0] s_id,
    output logic           s_last,
    output logic           s_valid,
    input  logic           s_ready
);

    state_t        state_q, state_d;
    logic          accept, s_hs;
    logic          m_ready_d, s_valid_d, load_first, load_next;
    logic [AW-1:0] nxt_addr_q;
    logic [8:0]    rem_q;

    logic [AW-1:0] calc_addr, calc_next;
    logic [8:0]    calc_rem, calc_chunk;
    logic [2:0]    calc_size;
    logic [7:0]    calc_len;
    logic          calc_last;

    assign accept = m_valid & m_ready;
    assign s_hs   = s_valid & s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)         state_d = ST_BUSY;
            ST_BUSY: if (s_hs && s_last) state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next state, so neither
    // m_ready nor s_valid has a combinational path from any input.
    always_comb begin
        m_ready_d  = (state_d == ST_IDLE);
        s_valid_d  = (state_d == ST_BUSY);
        load_first = (state_q == ST_IDLE) && accept;
        load_next  = (state_q == ST_BUSY) && s_hs && !s_last;
    end

    // In IDLE the calculator sizes the first chunk of the incoming command;
    // in BUSY it sizes the chunk after the one currently presented.
    always_comb begin
        if (state_q == ST_IDLE) begin
            calc_addr = m_addr;
            calc_rem  = {1'b0, m_len} + 9'd1;
            calc_size = m_size;
        end else begin
            calc_addr = nxt_addr_q;
            calc_rem  = rem_q;
            calc_size = s_size;
        end
    end

    axi_split_calc #(
        .AW        (AW),
        .MAX_BEATS (MAX_BEATS)
    ) u_calc (
        .addr      (calc_addr),
        .rem       (calc_rem),
        .size      (calc_size),
        .chunk     (calc_chunk),
        .s_len     (calc_len),
        .s_last    (calc_last),
        .next_addr (calc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready    <= 1'b0;
            s_valid    <= 1'b0;
            s_addr     <= '0;
            s_len      <= '0;
            s_size     <= '0;
            s_burst    <= '0;
            s_id       <= '0;
            s_last     <= 1'b0;
            nxt_addr_q <= '0;
            rem_q      <= '0;
        end else begin
            m_ready <= m_ready_d;
            s_valid <= s_valid_d;
            if (load_first) begin
                s_addr     <= m_addr;
                s_size     <= m_size;
                s_burst    <= m_burst;
                s_id       <= m_id;
                nxt_addr_q <= calc_next;
                rem_q      <= calc_rem - calc_chunk;
                if (m_burst == BURST_INCR) begin
                    s_len  <= calc_len;
                    s_last <= calc_last;
                end else begin
                    s_len  <= m_len;
                    s_last <= 1'b1;
                end
            end else if (load_next) begin
                s_addr     <= nxt_addr_q;
                s_len      <= calc_len;
                s_last     <= calc_last;
                nxt_addr_q <= calc_next;
                rem_q      <= rem_q - calc_chunk;
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_split.sv
// Bench for axi_burst_split: hand-written vector table, stall and reset sequences,
// then random commands against a beat-level reference model.
module tb_axi_burst_split;

    localparam int AW = 32, IDW = 4, MAXB = 16;

    logic           clk = 1'b0, rst_n = 1'b0;
    logic [AW-1:0]  m_addr = '0;
    logic [7:0]     m_len = '0;
    logic [2:0]     m_size = '0;
    logic [1:0]     m_burst = '0;
    logic [IDW-1:0] m_id = '0;
    logic           m_valid = 1'b0, m_ready;
    logic [AW-1:0]  s_addr;
    logic [7:0]     s_len;
    logic [2:0]     s_size;
    logic [1:0]     s_burst;
    logic [IDW-1:0] s_id;
    logic           s_last, s_valid;
    logic           s_ready = 1'b0;

    always #5 clk = ~clk;

    axi_burst_split #(.AW(AW), .IDW(IDW), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_addr(m_addr), .m_len(m_len), .m_size(m_size), .m_burst(m_burst), .m_id(m_id),
        .m_valid(m_valid), .m_ready(m_ready),
        .s_addr(s_addr), .s_len(s_len), .s_size(s_size), .s_burst(s_burst), .s_id(s_id),
        .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready)
    );

    typedef struct packed {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0]       n;
        logic [3:0][31:0] ea;
        logic [3:0][7:0]  el;
    } vec_t;

    vec_t tbl [10];
    int   n_vec = 0, n_err = 0;

    logic [31:0] exp_a[$], act_a[$];
    logic [7:0]  exp_l[$], act_l[$];
    logic        exp_z[$], act_z[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] sz, input logic [1:0] b, input logic [3:0] n,
                           input logic [31:0] a0, input logic [7:0] l0,
                           input logic [31:0] a1, input logic [7:0] l1,
                           input logic [31:0] a2, input logic [7:0] l2,
                           input logic [31:0] a3, input logic [7:0] l3);
        tbl[i].addr = a;  tbl[i].len = l; tbl[i].size = sz; tbl[i].burst = b; tbl[i].n = n;
        tbl[i].ea[0] = a0; tbl[i].el[0] = l0; tbl[i].ea[1] = a1; tbl[i].el[1] = l1;
        tbl[i].ea[2] = a2; tbl[i].el[2] = l2; tbl[i].ea[3] = a3; tbl[i].el[3] = l3;
    endtask

    // Reference: walk every beat address and open a new sub-burst whenever the
    // current one is full or the beat lands in a different 4 KB page.
    task automatic model(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                         input logic [1:0] b);
        logic [31:0] bytes, al, start, ba;
        int cnt;
        exp_a.delete(); exp_l.delete(); exp_z.delete();
        if (b != 2'd1) begin
            exp_a.push_back(a); exp_l.push_back(l); exp_z.push_back(1'b1);
        end else begin
            bytes = 32'd1 << sz;
            al    = a & ~(bytes - 32'd1);
            start = a;
            cnt   = 0;
            for (int i = 0; i <= int'(l); i++) begin
                ba = (i == 0) ? a : al + bytes * 32'(i);
                if (i > 0 && (cnt == MAXB || ba[31:12] != start[31:12])) begin
                    exp_a.push_back(start); exp_l.push_back(8'(cnt - 1)); exp_z.push_back(1'b0);
                    start = ba;
                    cnt   = 0;
                end
                cnt++;
            end
            exp_a.push_back(start); exp_l.push_back(8'(cnt - 1)); exp_z.push_back(1'b1);
        end
    endtask

    // Entered and left on a negedge. Holds s_ready low for stall_cyc cycles on
    // sub-burst stall_idx and checks the presented sub-burst does not move.
    task automatic do_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                          input logic [1:0] b, input logic [3:0] id,
                          input int stall_idx, input int stall_cyc, input string tag);
        int          waited, busy, stalls;
        logic        done;
        logic [31:0] hold_a;
        logic [7:0]  hold_l;
        act_a.delete(); act_l.delete(); act_z.delete();
        m_addr = a; m_len = l; m_size = sz; m_burst = b; m_id = id; m_valid = 1'b1; s_ready = 1'b1;
        waited = 0;
        while (!m_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, " accept"}, m_ready, 1);
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_addr = $urandom; m_len = 8'($urandom); m_size = 3'($urandom);
        m_burst = 2'($urandom); m_id = 4'($urandom);
        @(negedge clk);
        chk({tag, " latency s_valid"}, s_valid, 1);
        busy = 0; stalls = 0; done = 1'b0; hold_a = '0; hold_l = '0;
        while (!done && busy < 700) begin
            if (!s_valid) begin
                chk({tag, " s_valid dropped"}, s_valid, 1);
                busy = 700;
            end else begin
                busy++;
                if (act_a.size() == stall_idx && stalls < stall_cyc) begin
                    if (stalls == 0) begin
                        hold_a = s_addr; hold_l = s_len;
                    end else begin
                        chk({tag, " stall s_addr"}, s_addr, hold_a);
                        chk({tag, " stall s_len"}, s_len, hold_l);
                    end
                    chk({tag, " stall m_ready"}, m_ready, 0);
                    s_ready = 1'b0;
                    stalls++;
                end else begin
                    s_ready = 1'b1;
                    act_a.push_back(s_addr); act_l.push_back(s_len); act_z.push_back(s_last);
                    chk({tag, " s_size"}, s_size, sz);
                    chk({tag, " s_burst"}, s_burst, b);
                    chk({tag, " s_id"}, s_id, id);
                    if (s_last) done = 1'b1;
                end
                @(negedge clk);
            end
        end
        chk({tag, " completed"}, done, 1);
        chk({tag, " m_ready after split"}, m_ready, 1);
        chk({tag, " s_valid after split"}, s_valid, 0);
        chk({tag, " busy cycles"}, busy, exp_a.size() + stalls);
    endtask

    task automatic compare(input string tag);
        chk({tag, " sub-burst count"}, act_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < act_a.size(); i++) begin
            chk($sformatf("%s sub%0d addr", tag, i), act_a[i], exp_a[i]);
            chk($sformatf("%s sub%0d len", tag, i), act_l[i], exp_l[i]);
            chk($sformatf("%s sub%0d last", tag, i), act_z[i], exp_z[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //       addr        len sz b  n   sub0           sub1           sub2           sub3
        set_vec(0, 32'h0000, 63, 3, 1, 4, 32'h000, 15, 32'h080, 15, 32'h100, 15, 32'h180, 15);
        set_vec(1, 32'h0FF0,  7, 2, 1, 2, 32'hFF0,  3, 32'h1000, 3, 0, 0, 0, 0);
        set_vec(2, 32'h0FFA,  3, 2, 1, 2, 32'hFFA,  1, 32'h1000, 1, 0, 0, 0, 0);
        set_vec(3, 32'h1234, 255, 2, 0, 1, 32'h1234, 255, 0, 0, 0, 0, 0, 0);
        set_vec(4, 32'h2044,  7, 2, 2, 1, 32'h2044, 7, 0, 0, 0, 0, 0, 0);
        set_vec(5, 32'h0FF0, 15, 2, 3, 1, 32'hFF0, 15, 0, 0, 0, 0, 0, 0);
        set_vec(6, 32'h3000,  0, 0, 1, 1, 32'h3000, 0, 0, 0, 0, 0, 0, 0);
        set_vec(7, 32'h0010, 47, 0, 1, 3, 32'h010, 15, 32'h020, 15, 32'h030, 15, 0, 0);
        set_vec(8, 32'h0F80, 31, 3, 1, 2, 32'hF80, 15, 32'h1000, 15, 0, 0, 0, 0);
        set_vec(9, 32'h5FFF,  1, 0, 1, 2, 32'h5FFF, 0, 32'h6000, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("reset s_valid", s_valid, 0);
        chk("reset m_ready", m_ready, 0);
        chk("reset s_addr", s_addr, 0);
        chk("reset s_len", s_len, 0);
        chk("reset s_last", s_last, 0);
        chk("reset s_id", s_id, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("m_ready after reset release", m_ready, 1);

        for (int i = 0; i < 10; i++) begin
            exp_a.delete(); exp_l.delete(); exp_z.delete();
            for (int k = 0; k < int'(tbl[i].n); k++) begin
                exp_a.push_back(tbl[i].ea[k]);
                exp_l.push_back(tbl[i].el[k]);
                exp_z.push_back(k == int'(tbl[i].n) - 1);
            end
            do_cmd(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, 4'(i),
                   (i == 7) ? 1 : -1, 5, $sformatf("vec%0d", i));
            compare($sformatf("vec%0d", i));
        end

        // Reset while the second of four sub-bursts is presented.
        m_addr = 32'h0; m_len = 63; m_size = 3; m_burst = 1; m_id = 4'h5; m_valid = 1'b1; s_ready = 1'b1;
        @(posedge clk);
        #1 m_valid = 1'b0;
        @(negedge clk);
        chk("rst seq sub0 addr", s_addr, 32'h000);
        @(negedge clk);
        chk("rst seq sub1 valid", s_valid, 1);
        chk("rst seq sub1 addr", s_addr, 32'h080);
        s_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst s_valid", s_valid, 0);
        chk("async rst m_ready", m_ready, 0);
        chk("async rst s_addr", s_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        s_ready = 1'b1;
        chk("m_ready before first edge", m_ready, 0);
        @(negedge clk);
        chk("m_ready one edge after release", m_ready, 1);
        for (int k = 0; k < 4; k++) begin
            chk("no stale sub-burst", s_valid, 0);
            @(negedge clk);
        end
        model(32'h0000_0FF0, 7, 2, 1);
        do_cmd(32'h0000_0FF0, 7, 2, 1, 4'h9, -1, 0, "post-reset");
        compare("post-reset");

        for (int r = 0; r < 40; r++) begin
            logic [31:0] a;
            logic [7:0]  l;
            logic [2:0]  sz;
            logic [1:0]  b;
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
            l  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
            sz = 3'($urandom_range(0, 4));
            b  = 2'($urandom_range(0, 3));
            model(a, l, sz, b);
            do_cmd(a, l, sz, b, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   $sformatf("rnd%0d", r));
            compare($sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
